stoch_window_readout: RTL and testbench

//  Downstream consumer of the stochastic decorrelator: converts a unipolar

---
 rtl/stoch_window_readout.sv | 95 +++++++++
 tb/tb_stoch_window_readout.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stoch_window_readout.sv
// Counts ones in a stochastic bitstream over a window of 2**WINDOW_LOG2 sampled
// bits and presents the count through a valid/ready handshake.
module stoch_window_readout #(
  parameter  int WINDOW_LOG2 = 8,
  localparam int OUT_WIDTH   = WINDOW_LOG2 + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 en,
  input  logic                 a,
  output logic [OUT_WIDTH-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 state, state_next;
  logic [WINDOW_LOG2-1:0] bit_cnt, bit_cnt_next;
  logic [OUT_WIDTH-1:0]   ones_cnt, ones_cnt_next;
  logic [OUT_WIDTH-1:0]   y_next;
  logic                   overrun_next;
  logic [OUT_WIDTH-1:0]   a_ext;

  assign a_ext = {{(OUT_WIDTH-1){1'b0}}, a};

  // busy and y_valid decode the state register directly, so they stay registered.
  assign busy    = (state == ACCUM);
  assign y_valid = (state == DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      y        <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      ones_cnt <= ones_cnt_next;
      y        <= y_next;
      overrun  <= overrun_next;
    end
  end

  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    ones_cnt_next = ones_cnt;
    y_next        = y;
    overrun_next  = overrun;
    case (state)
      IDLE: begin
        if (start) begin
          state_next    = ACCUM;
          bit_cnt_next  = '0;
          ones_cnt_next = '0;
          overrun_next  = 1'b0;
        end
      end
      ACCUM: begin
        // A restart discards the bit presented in the same cycle.
        if (start) begin
          bit_cnt_next  = '0;
          ones_cnt_next = '0;
          overrun_next  = 1'b0;
        end else if (en) begin
          bit_cnt_next  = bit_cnt + 1'b1;
          ones_cnt_next = ones_cnt + a_ext;
          if (bit_cnt == {WINDOW_LOG2{1'b1}}) begin
            y_next     = ones_cnt + a_ext;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (y_ready && start) begin
          state_next    = ACCUM;
          bit_cnt_next  = '0;
          ones_cnt_next = '0;
          overrun_next  = 1'b0;
        end else begin
          if (en) overrun_next = 1'b1;
          if (y_ready) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stoch_window_readout.sv
// Directed bench for stoch_window_readout with a 16-bit window.
module tb_stoch_window_readout;

  localparam int WL2 = 4;
  localparam int OW  = WL2 + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          en = 1'b0;
  logic          a = 1'b0;
  logic          y_ready = 1'b0;
  logic [OW-1:0] y;
  logic          y_valid;
  logic          busy;
  logic          overrun;

  int compared   = 0;
  int mismatched = 0;

  stoch_window_readout #(.WINDOW_LOG2(WL2)) dut (
    .CLK(CLK), .RST(RST), .start(start), .en(en), .a(a),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int model_ones;
    int sampled;

    // Reset state
    RST = 1'b1;
    #3;
    chk("rst_y", 32'(y), 0);
    chk("rst_valid", 32'(y_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    RST = 1'b0;
    tick();

    // en/a ignored in IDLE
    en = 1'b1; a = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);
    en = 1'b0;

    // Window of all ones
    start = 1'b1; tick(); start = 1'b0;
    chk("ones_busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; a = 1'b1;
      tick();
      if (i == 14) chk("ones_valid_early", 32'(y_valid), 0);
    end
    en = 1'b0;
    chk("ones_y", 32'(y), 16);
    chk("ones_valid", 32'(y_valid), 1);
    chk("ones_busy_done", 32'(busy), 0);
    y_ready = 1'b1; tick(); y_ready = 1'b0;
    chk("ones_accept_valid", 32'(y_valid), 0);
    chk("ones_accept_y", 32'(y), 16);

    // en toggling, sampled bits alternate 1,0 -> 8 ones over 32 cycles
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      en = (i % 2 == 0);
      a  = ((i / 2) % 2 == 0);
      tick();
      if (i == 29) chk("alt_valid_early", 32'(y_valid), 0);
    end
    en = 1'b0; a = 1'b0;
    chk("alt_y", 32'(y), 8);
    chk("alt_valid", 32'(y_valid), 1);
    chk("alt_overrun", 32'(overrun), 0);
    y_ready = 1'b1; tick(); y_ready = 1'b0;

    // Restart after 7 ones; start beats en in the restart cycle
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; a = 1'b1; tick();
    end
    chk("abort_valid", 32'(y_valid), 0);
    start = 1'b1; en = 1'b1; a = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; a = 1'b0; tick();
    end
    en = 1'b0;
    chk("abort_y", 32'(y), 0);
    chk("abort_valid_done", 32'(y_valid), 1);

    // Stall in DONE with en high -> overrun, y stable
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; a = 1'b1; tick();
      chk("stall_y", 32'(y), 0);
      chk("stall_valid", 32'(y_valid), 1);
      chk("stall_overrun", 32'(overrun), 1);
    end
    en = 1'b0;
    // start without ready is ignored
    start = 1'b1; tick();
    chk("start_noready_valid", 32'(y_valid), 1);
    y_ready = 1'b1; tick(); start = 1'b0; y_ready = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_valid", 32'(y_valid), 0);
    chk("b2b_overrun", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; a = (i < 5); tick();
    end
    en = 1'b0;
    chk("five_y", 32'(y), 5);
    y_ready = 1'b1; tick(); y_ready = 1'b0;
    chk("five_idle_valid", 32'(y_valid), 0);
    chk("five_idle_busy", 32'(busy), 0);

    // Async reset mid-window
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; a = 1'b1; tick();
    end
    en = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("arst_y", 32'(y), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(y_valid), 0);
    chk("arst_overrun", 32'(overrun), 0);
    #1 RST = 1'b0;
    tick();
    chk("arst_idle_busy", 32'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; a = 1'b1; tick();
    end
    en = 1'b0;
    chk("arst_after_y", 32'(y), 16);
    y_ready = 1'b1; tick(); y_ready = 1'b0;

    // Random p=0.25 stream, 100 back-to-back windows against a count model
    start = 1'b1; tick(); start = 1'b0;
    for (int w = 0; w < 100; w++) begin
      model_ones = 0;
      sampled    = 0;
      while (sampled < 16) begin
        en = ($urandom_range(0, 3) != 0);
        a  = ($urandom_range(0, 3) == 0);
        if (en) begin
          sampled++;
          if (a) model_ones++;
        end
        tick();
      end
      en = 1'b0;
      chk("rand_valid", 32'(y_valid), 1);
      chk("rand_y", 32'(y), 32'(model_ones));
      start = 1'b1; y_ready = 1'b1; tick(); start = 1'b0; y_ready = 1'b0;
      chk("rand_b2b_busy", 32'(busy), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
